// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 3-8 decoder between 8 requesters, with a one-cycle break-before-make gap.
// Optional hold limit: define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles.
//
// state | meaning
// IDLE  | no grant, decoder disabled, waiting for any request
// GRANT | decoder enabled for the winner held in ptr_q
// GAP   | one dead cycle between grants, decoder disabled
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HW       = 8
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iReq,
    output logic [2:0] oSel,
    output logic [1:0] oEna,
    output logic [7:0] oGnt,
    output logic       oValid,
    output logic       oTimeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [1:0] ENA_ON  = 2'b10;
    localparam logic [1:0] ENA_OFF = 2'b01;

    state_t        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [HW-1:0] cnt_q, cnt_d;
    logic [2:0]    sel_q, sel_d;
    logic [1:0]    ena_q, ena_d;
    logic [7:0]    gnt_q, gnt_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;

    logic [2:0]    winner;
    logic          hold_hit;
    logic          released;
    logic          revoke;

    // First set request scanning from ptr+1 upward, wrapping 7 -> 0.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [2:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        winner    = rr_pick(iReq, ptr_q);
        hold_hit  = (cnt_q == HW'(MAX_HOLD - 1));
        released  = !iReq[ptr_q];
        revoke    = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (|iReq) begin
                    state_d = ST_GRANT;
                    ptr_d   = winner;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
`ifdef ARB_TIMEOUT_EN
                revoke    = released || hold_hit;
                // A release coinciding with the limit is a normal release, not a timeout.
                timeout_d = !released && hold_hit;
`else
                revoke    = released;
`endif
                if (revoke) begin
                    state_d = ST_GAP;
                end else if (!hold_hit) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the next state so every output is a plain flop.
        if (state_d == ST_GRANT) begin
            sel_d   = ptr_d;
            ena_d   = ENA_ON;
            gnt_d   = ~(8'b1 << ptr_d);
            valid_d = 1'b1;
        end else begin
            sel_d   = 3'd0;
            ena_d   = ENA_OFF;
            gnt_d   = 8'hFF;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 3'd7;
            cnt_q     <= '0;
            sel_q     <= 3'd0;
            ena_q     <= ENA_OFF;
            gnt_q     <= 8'hFF;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            ena_q     <= ena_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign oSel     = sel_q;
    assign oEna     = ena_q;
    assign oGnt     = gnt_q;
    assign oValid   = valid_q;
    assign oTimeout = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter; observed word is {oSel, oEna, oGnt, oValid, oTimeout}.
module tb_decoder_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [2:0] sel;
    logic [1:0] ena;
    logic [7:0] gnt;
    logic       valid;
    logic       tmo;
    logic [14:0] obs;

    int checks = 0;
    int errors = 0;

    localparam logic [14:0] OFF     = {3'd0, 2'b01, 8'hFF, 1'b0, 1'b0};
    localparam logic [14:0] OFF_TMO = {3'd0, 2'b01, 8'hFF, 1'b0, 1'b1};

    decoder_rr_arbiter #(.MAX_HOLD(4), .HW(8)) dut (
        .iClk    (clk),
        .iRst    (rst),
        .iReq    (req),
        .oSel    (sel),
        .oEna    (ena),
        .oGnt    (gnt),
        .oValid  (valid),
        .oTimeout(tmo)
    );

    assign obs = {sel, ena, gnt, valid, tmo};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] granted(input int k);
        logic [7:0] g;
        g = ~(8'b1 << k);
        return {3'(k), 2'b10, g, 1'b1, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== OFF) begin
                errors++;
                $display("FAIL reset_hold[%0d] got %h exp %h", i, obs, OFF);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs !== granted(0)) begin
            errors++;
            $display("FAIL reset_first_grant got %h exp %h", obs, granted(0));
        end
    endtask

    task automatic test_rotation();
        int order [4] = '{0, 2, 7, 0};
        do_reset();
        req = 8'b1000_0101;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== granted(order[i])) begin
                errors++;
                $display("FAIL rotation_grant[%0d] got %h exp %h", i, obs, granted(order[i]));
            end
            if (i < 3) begin
                req = 8'b1000_0101 & ~(8'b1 << order[i]);
                step();
                checks++;
                if (obs !== OFF) begin
                    errors++;
                    $display("FAIL rotation_gap[%0d] got %h exp %h", i, obs, OFF);
                end
                req = 8'b1000_0101;
            end
        end
    endtask

    task automatic test_wraparound();
        do_reset();
        req = 8'b0100_0000;
        step();
        checks++;
        if (obs !== granted(6)) begin
            errors++;
            $display("FAIL wrap_grant6 got %h exp %h", obs, granted(6));
        end
        req = 8'b0000_0001;
        step();
        req = 8'b0100_0001;
        step();
        checks++;
        if (obs !== granted(0)) begin
            errors++;
            $display("FAIL wrap_grant0 got %h exp %h", obs, granted(0));
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'b0000_1001;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== granted(0)) begin
                errors++;
                $display("FAIL hold_cycle[%0d] got %h exp %h", i, obs, granted(0));
            end
        end
`ifdef ARB_TIMEOUT_EN
        step();
        checks++;
        if (obs !== OFF_TMO) begin
            errors++;
            $display("FAIL timeout_gap got %h exp %h", obs, OFF_TMO);
        end
        step();
        checks++;
        if (obs !== granted(3)) begin
            errors++;
            $display("FAIL timeout_next_grant got %h exp %h", obs, granted(3));
        end
`else
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (obs !== granted(0)) begin
                errors++;
                $display("FAIL no_limit_hold[%0d] got %h exp %h", i, obs, granted(0));
            end
        end
`endif
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 8'h20;
        step();
        step();
        checks++;
        if (obs !== granted(5)) begin
            errors++;
            $display("FAIL midrst_grant5 got %h exp %h", obs, granted(5));
        end
        rst = 1'b1;
        step();
        checks++;
        if (obs !== OFF) begin
            errors++;
            $display("FAIL midrst_drop got %h exp %h", obs, OFF);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs !== granted(5)) begin
            errors++;
            $display("FAIL midrst_regrant got %h exp %h", obs, granted(5));
        end
        // Requester 6 must not preempt; after reset ptr=7 so 5 beats 6.
        req = 8'h60;
        step();
        checks++;
        if (obs !== granted(5)) begin
            errors++;
            $display("FAIL no_preempt got %h exp %h", obs, granted(5));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (obs !== granted(5)) begin
            errors++;
            $display("FAIL midrst_ptr_reset got %h exp %h", obs, granted(5));
        end
    endtask

    task automatic test_idle_return();
        do_reset();
        req = 8'h10;
        step();
        checks++;
        if (obs !== granted(4)) begin
            errors++;
            $display("FAIL idle_grant4 got %h exp %h", obs, granted(4));
        end
        req = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== OFF) begin
                errors++;
                $display("FAIL idle_off[%0d] got %h exp %h", i, obs, OFF);
            end
        end
        req = 8'h10;
        step();
        checks++;
        if (obs !== granted(4)) begin
            errors++;
            $display("FAIL idle_regrant got %h exp %h", obs, granted(4));
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        test_reset();
        test_rotation();
        test_wraparound();
        test_timeout();
        test_reset_mid_grant();
        test_idle_return();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
